// File: rtl/otter_cu_pkg.sv
// Shared types for the OTTER control unit: RV32I major opcodes, FSM states,
// the SYSTEM func3 codes the control unit acts on, and an opcode legality helper.
package otter_cu_pkg;

  typedef enum logic [6:0] {
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    BRANCH = 7'b1100011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    OP_IMM = 7'b0010011,
    OP_RG3 = 7'b0110011,
    SYS    = 7'b1110011
  } opcode_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    WB    = 2'd2,
    INTR  = 2'd3
  } state_t;

  localparam logic [2:0] F3_MRET  = 3'b000;
  localparam logic [2:0] F3_CSRRW = 3'b001;

  // True for any opcode the control unit knows how to sequence.
  function automatic logic is_known_opcode(input logic [6:0] op);
    case (op)
      LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP_RG3, SYS:
        is_known_opcode = 1'b1;
      default:
        is_known_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/otter_cu_fsm_int_prio_enc.sv
// Fixed-priority encoder for pending interrupts: index 0 wins.
module int_prio_enc #(
  parameter  int NUM_INT = 4,
  localparam int CW      = $clog2(NUM_INT + 1)
) (
  input  logic [NUM_INT-1:0] pending,
  output logic               valid,
  output logic [CW-1:0]      index
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid = |pending;
    index = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (pending[i]) index = CW'(i);
    end
  end

endmodule

// File: rtl/otter_cu_fsm.sv
// OTTER multicycle control unit: FETCH -> EXEC [-> WB] [-> INTR] -> FETCH.
// Strobes are combinational on state, opcode, func3 and mem_ack, and are all
// held at zero while RST is high. Memory handshake: a request strobe
// (mem_rden1, mem_rden2, mem_we2) stays high until the cycle in which
// mem_ack is high; that cycle completes the access and the FSM moves on at
// the next rising edge. Interrupts are only taken when EXEC or WB finish.
// Build option: define CU_ILLEGAL_TRAP_EN to trap unknown opcodes into INTR
// with int_cause = NUM_INT; otherwise unknown opcodes behave as a NOP.
module otter_cu_fsm
  import otter_cu_pkg::*;
#(
  parameter  int NUM_INT = 4,
  localparam int CW      = $clog2(NUM_INT + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [6:0]         opcode,
  input  logic [2:0]         func3,
  input  logic [NUM_INT-1:0] intr,
  input  logic               mie,
  input  logic               mem_ack,
  output logic               pc_write,
  output logic               reg_write,
  output logic               mem_rden1,
  output logic               mem_rden2,
  output logic               mem_we2,
  output logic               csr_we,
  output logic               int_taken,
  output logic               mret_exec,
  output logic [CW-1:0]      int_cause,
  output state_t             state_dbg
);

  state_t             state;
  logic [NUM_INT-1:0] pending;
  logic [NUM_INT-1:0] clr_mask;
  logic               trap_q;     // current INTR visit is an illegal-opcode trap
  logic               enc_valid;
  logic [CW-1:0]      enc_index;
  logic               irq_go;

  int_prio_enc #(.NUM_INT(NUM_INT)) u_prio (
    .pending (pending),
    .valid   (enc_valid),
    .index   (enc_index)
  );

  assign irq_go    = mie & enc_valid;
  assign state_dbg = state;

  // A genuine interrupt service retires its pending bit; a trap leaves pending alone.
  assign clr_mask = (state == INTR && !trap_q && enc_valid) ? (NUM_INT'(1) << enc_index) : '0;

`ifdef CU_ILLEGAL_TRAP_EN
  logic known_op;
  assign known_op = is_known_opcode(opcode);
`endif

  // Pending latch: new requests OR in after the clear, so set beats clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) pending <= '0;
    else     pending <= (pending & ~clr_mask) | intr;
  end

  // Main sequencer: advance on ack or instruction completion.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= FETCH;
      trap_q <= 1'b0;
    end else begin
      case (state)
        FETCH: if (mem_ack) state <= EXEC;
        EXEC: begin
          if (opcode == LOAD) begin
            if (mem_ack) state <= WB;
          end else if (opcode == STORE) begin
            if (mem_ack) state <= irq_go ? INTR : FETCH;
          end
`ifdef CU_ILLEGAL_TRAP_EN
          else if (!known_op) begin
            state  <= INTR;
            trap_q <= 1'b1;
          end
`endif
          else begin
            state <= irq_go ? INTR : FETCH;
          end
        end
        WB:   state <= irq_go ? INTR : FETCH;
        INTR: begin
          state  <= FETCH;
          trap_q <= 1'b0;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Strobe decode; everything is forced low while reset is asserted.
  always_comb begin
    pc_write  = 1'b0;
    reg_write = 1'b0;
    mem_rden1 = 1'b0;
    mem_rden2 = 1'b0;
    mem_we2   = 1'b0;
    csr_we    = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;
    int_cause = '0;
    if (!RST) begin
      case (state)
        FETCH: mem_rden1 = 1'b1;
        EXEC: begin
          case (opcode)
            LOAD:  mem_rden2 = 1'b1;
            STORE: begin
              mem_we2  = 1'b1;
              pc_write = mem_ack;
            end
            LUI, AUIPC, JAL, JALR, OP_IMM, OP_RG3: begin
              pc_write  = 1'b1;
              reg_write = 1'b1;
            end
            BRANCH: pc_write = 1'b1;
            SYS: begin
              pc_write = 1'b1;
              if (func3 == F3_CSRRW) begin
                reg_write = 1'b1;
                csr_we    = 1'b1;
              end else if (func3 == F3_MRET) begin
                mret_exec = 1'b1;
              end
            end
`ifdef CU_ILLEGAL_TRAP_EN
            default: ;
`else
            default: pc_write = 1'b1;
`endif
          endcase
        end
        WB: begin
          pc_write  = 1'b1;
          reg_write = 1'b1;
        end
        INTR: begin
          pc_write  = 1'b1;
          int_taken = 1'b1;
          int_cause = trap_q ? CW'(NUM_INT) : enc_index;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Testbench for otter_cu_fsm. Expected strobe vectors are built per
// instruction from the architectural rules (phases, wait counts, pending
// mask as a plain bit vector), then compared cycle by cycle.
module tb_otter_cu_fsm;

  localparam int NUM_INT = 4;
  localparam int CW      = $clog2(NUM_INT + 1);
  localparam int VW      = 8 + CW;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_RG3    = 7'b0110011;
  localparam logic [6:0] OPC_SYS    = 7'b1110011;
  localparam logic [6:0] OPC_BAD    = 7'h7F;

  // clock / reset / DUT
  logic CLK = 1'b0;
  logic RST;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [NUM_INT-1:0] intr;
  logic mie, mem_ack;
  logic pc_write, reg_write, mem_rden1, mem_rden2, mem_we2, csr_we, int_taken, mret_exec;
  logic [CW-1:0] int_cause;
  otter_cu_pkg::state_t state_dbg;

  always #5 CLK = ~CLK;

  otter_cu_fsm #(.NUM_INT(NUM_INT)) dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .func3(func3), .intr(intr),
    .mie(mie), .mem_ack(mem_ack), .pc_write(pc_write), .reg_write(reg_write),
    .mem_rden1(mem_rden1), .mem_rden2(mem_rden2), .mem_we2(mem_we2),
    .csr_we(csr_we), .int_taken(int_taken), .mret_exec(mret_exec),
    .int_cause(int_cause), .state_dbg(state_dbg)
  );

  // scoreboard
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] obs_q[$];
  logic [NUM_INT-1:0] m_pending;
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // reference model helpers
  function automatic logic [VW-1:0] ev(input logic pc, input logic rg, input logic r1,
                                       input logic r2, input logic we, input logic csr,
                                       input logic it, input logic mr, input logic [CW-1:0] cause);
    return {pc, rg, r1, r2, we, csr, it, mr, cause};
  endfunction

  function automatic logic [VW-1:0] obs_now();
    return {pc_write, reg_write, mem_rden1, mem_rden2, mem_we2, csr_we, int_taken, mret_exec, int_cause};
  endfunction

  function automatic int lowest(input logic [NUM_INT-1:0] p);
    for (int i = 0; i < NUM_INT; i++) if (p[i]) return i;
    return 0;
  endfunction

  function automatic logic legal(input logic [6:0] op);
    return (op == OPC_LUI) || (op == OPC_AUIPC) || (op == OPC_JAL) || (op == OPC_JALR) ||
           (op == OPC_BRANCH) || (op == OPC_LOAD) || (op == OPC_STORE) || (op == OPC_IMM) ||
           (op == OPC_RG3) || (op == OPC_SYS);
  endfunction

  // Single-cycle EXEC behaviour of non-memory instructions.
  function automatic logic [VW-1:0] exec_expect(input logic [6:0] op, input logic [2:0] f3);
    if (op == OPC_BRANCH) return ev(1, 0, 0, 0, 0, 0, 0, 0, '0);
    if (op == OPC_SYS) begin
      if (f3 == 3'b001) return ev(1, 1, 0, 0, 0, 1, 0, 0, '0);
      if (f3 == 3'b000) return ev(1, 0, 0, 0, 0, 0, 0, 1, '0);
      return ev(1, 0, 0, 0, 0, 0, 0, 0, '0);
    end
    if (legal(op)) return ev(1, 1, 0, 0, 0, 0, 0, 0, '0);
    return ev(1, 0, 0, 0, 0, 0, 0, 0, '0);
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [NUM_INT-1:0] rnd_intr(input bit en);
    logic [NUM_INT-1:0] v;
    v = '0;
    if (en && $urandom_range(0, 5) == 0) v[$urandom_range(0, NUM_INT - 1)] = 1'b1;
    return v;
  endfunction

  // driver: one clock cycle; inputs applied after the falling edge, outputs sampled 2ns later
  task automatic drive_cycle(input logic [6:0] op, input logic [2:0] f3, input logic ack,
                             input logic mie_v, input logic [NUM_INT-1:0] iv,
                             input logic [NUM_INT-1:0] clr, input logic [VW-1:0] e);
    @(negedge CLK);
    opcode = op; func3 = f3; mem_ack = ack; mie = mie_v; intr = iv;
    #2;
    exp_q.push_back(e);
    obs_q.push_back(obs_now());
    m_pending = (m_pending & ~clr) | iv;
  endtask

  // One whole instruction: fw / ew are the number of un-acked cycles per memory phase.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int fw, input int ew,
                           input logic mie_v, input logic [NUM_INT-1:0] intr_first,
                           input logic [NUM_INT-1:0] intr_in_intr, input bit rnd);
    logic go;
    logic [NUM_INT-1:0] clr;
    go = 1'b0;
    for (int i = 0; i <= fw; i++)
      drive_cycle(op, f3, 1'(i == fw), mie_v, (i == 0) ? intr_first : rnd_intr(rnd), '0,
                  ev(0, 0, 1, 0, 0, 0, 0, 0, '0));
    if (op == OPC_LOAD) begin
      for (int i = 0; i <= ew; i++)
        drive_cycle(op, f3, 1'(i == ew), mie_v, rnd_intr(rnd), '0, ev(0, 0, 0, 1, 0, 0, 0, 0, '0));
      go = mie_v && (m_pending != 0);
      drive_cycle(op, f3, rbit(), mie_v, rnd_intr(rnd), '0, ev(1, 1, 0, 0, 0, 0, 0, 0, '0));
    end else if (op == OPC_STORE) begin
      for (int i = 0; i < ew; i++)
        drive_cycle(op, f3, 1'b0, mie_v, rnd_intr(rnd), '0, ev(0, 0, 0, 0, 1, 0, 0, 0, '0));
      go = mie_v && (m_pending != 0);
      drive_cycle(op, f3, 1'b1, mie_v, rnd_intr(rnd), '0, ev(1, 0, 0, 0, 1, 0, 0, 0, '0));
    end else if (!legal(op)) begin
`ifdef CU_ILLEGAL_TRAP_EN
      drive_cycle(op, f3, rbit(), mie_v, rnd_intr(rnd), '0, ev(0, 0, 0, 0, 0, 0, 0, 0, '0));
      drive_cycle(op, f3, rbit(), mie_v, intr_in_intr, '0, ev(1, 0, 0, 0, 0, 0, 1, 0, CW'(NUM_INT)));
`else
      go = mie_v && (m_pending != 0);
      drive_cycle(op, f3, rbit(), mie_v, rnd_intr(rnd), '0, ev(1, 0, 0, 0, 0, 0, 0, 0, '0));
`endif
    end else begin
      go = mie_v && (m_pending != 0);
      drive_cycle(op, f3, rbit(), mie_v, rnd_intr(rnd), '0, exec_expect(op, f3));
    end
    if (go) begin
      clr = '0;
      clr[lowest(m_pending)] = 1'b1;
      drive_cycle(op, f3, rbit(), mie_v, intr_in_intr, clr,
                  ev(1, 0, 0, 0, 0, 0, 1, 0, CW'(lowest(m_pending))));
    end
  endtask

  task automatic test_reset();
    logic [VW-1:0] o;
    RST = 1'b1; opcode = '0; func3 = '0; intr = '0; mie = 1'b0; mem_ack = 1'b0;
    m_pending = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      opcode = 7'($urandom); func3 = 3'($urandom); mem_ack = rbit(); mie = rbit();
      intr = NUM_INT'($urandom);
      #2;
      o = obs_now(); n_checks++;
      if (o !== '0) begin n_fail++; $display("FAIL reset_outputs cycle %0d: got %b expected %b", i, o, {VW{1'b0}}); end
      else n_pass++;
    end
    @(negedge CLK);
    intr = '0; mem_ack = 1'b0; mie = 1'b0; RST = 1'b0;
    #2;
    o = obs_now(); n_checks++;
    if (o !== ev(0, 0, 1, 0, 0, 0, 0, 0, '0)) begin
      n_fail++; $display("FAIL reset_release_fetch: got %b expected %b", o, ev(0, 0, 1, 0, 0, 0, 0, 0, '0));
    end else n_pass++;
  endtask

  task automatic test_op_imm();
    logic [VW-1:0] e, o;
    int k = 0;
    run_instr(OPC_IMM, 3'b000, 0, 0, 1'b0, '0, '0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL op_imm cycle %0d: got %b expected %b", k, o, e); end
      else n_pass++;
      k++;
    end
  endtask

  task automatic test_load_delayed();
    logic [VW-1:0] e, o;
    int k = 0;
    run_instr(OPC_LOAD, 3'b010, 2, 2, 1'b0, '0, '0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL load_delayed cycle %0d: got %b expected %b", k, o, e); end
      else n_pass++;
      k++;
    end
  endtask

  task automatic test_interrupts();
    logic [VW-1:0] e, o;
    int k = 0;
    run_instr(OPC_IMM, 3'b000, 0, 0, 1'b1, 4'b1010, '0, 0);   // INTR cause 1
    run_instr(OPC_STORE, 3'b010, 1, 1, 1'b1, '0, '0, 0);      // INTR cause 3
    run_instr(OPC_IMM, 3'b000, 0, 0, 1'b1, '0, '0, 0);        // nothing left
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL interrupts cycle %0d: got %b expected %b", k, o, e); end
      else n_pass++;
      k++;
    end
  endtask

  task automatic test_mie_gate();
    logic [VW-1:0] e, o;
    int k = 0;
    run_instr(OPC_IMM, 3'b000, 0, 0, 1'b0, 4'b0001, '0, 0);
    run_instr(OPC_LOAD, 3'b000, 1, 0, 1'b0, '0, '0, 0);
    run_instr(OPC_BRANCH, 3'b000, 0, 0, 1'b0, '0, '0, 0);
    run_instr(OPC_JAL, 3'b000, 0, 0, 1'b1, '0, '0, 0);        // INTR cause 0 now
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL mie_gate cycle %0d: got %b expected %b", k, o, e); end
      else n_pass++;
      k++;
    end
  endtask

  task automatic test_set_clear_collision();
    logic [VW-1:0] e, o;
    int k = 0;
    run_instr(OPC_IMM, 3'b000, 0, 0, 1'b1, 4'b0001, 4'b0001, 0); // re-raise during service
    run_instr(OPC_IMM, 3'b000, 0, 0, 1'b1, '0, '0, 0);           // serviced again
    run_instr(OPC_IMM, 3'b000, 0, 0, 1'b1, '0, '0, 0);           // now idle
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL set_clear cycle %0d: got %b expected %b", k, o, e); end
      else n_pass++;
      k++;
    end
  endtask

  task automatic test_opcodes();
    logic [VW-1:0] e, o;
    logic [6:0] ops [0:13];
    logic [2:0] f3s [0:13];
    int k = 0;
    ops = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_IMM,
            OPC_RG3, OPC_SYS, OPC_SYS, OPC_SYS, OPC_SYS, 7'h00};
    f3s = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd2, 3'd5, 3'd0, 3'b001, 3'b000, 3'b010, 3'b101, 3'd0};
    for (int i = 0; i < 14; i++)
      run_instr(ops[i], f3s[i], $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, '0, '0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL opcodes cycle %0d: got %b expected %b", k, o, e); end
      else n_pass++;
      k++;
    end
  endtask

  task automatic test_illegal();
    logic [VW-1:0] e, o;
    int k = 0;
    run_instr(OPC_BAD, 3'b000, 0, 0, 1'b0, 4'b0100, '0, 0);  // trap or NOP, pending kept
    run_instr(OPC_IMM, 3'b000, 0, 0, 1'b1, '0, '0, 0);       // pending bit 2 serviced
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL illegal cycle %0d: got %b expected %b", k, o, e); end
      else n_pass++;
      k++;
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] e, o;
    logic [6:0] tab [0:11];
    int k = 0;
    tab = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE,
            OPC_IMM, OPC_RG3, OPC_SYS, OPC_BAD, 7'h5B};
    for (int i = 0; i < 60; i++)
      run_instr(tab[$urandom_range(0, 11)], 3'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                rbit(), rnd_intr(1), rnd_intr(1), 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL random cycle %0d: got %b expected %b", k, o, e); end
      else n_pass++;
      k++;
    end
  endtask

  task automatic test_reset_mid_store();
    logic [VW-1:0] e, o;
    int k = 0;
    drive_cycle(OPC_STORE, 3'b010, 1'b1, 1'b1, '0, '0, ev(0, 0, 1, 0, 0, 0, 0, 0, '0));
    drive_cycle(OPC_STORE, 3'b010, 1'b0, 1'b1, 4'b0010, '0, ev(0, 0, 0, 0, 1, 0, 0, 0, '0));
    drive_cycle(OPC_STORE, 3'b010, 1'b0, 1'b1, '0, '0, ev(0, 0, 0, 0, 1, 0, 0, 0, '0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL store_wait cycle %0d: got %b expected %b", k, o, e); end
      else n_pass++;
      k++;
    end
    // reset in the middle of the wait: strobes drop without a clock edge
    RST = 1'b1;
    #1;
    o = obs_now(); n_checks++;
    if (o !== '0) begin n_fail++; $display("FAIL reset_mid_store: got %b expected %b", o, {VW{1'b0}}); end
    else n_pass++;
    m_pending = '0;
    @(negedge CLK);
    RST = 1'b0; mem_ack = 1'b0; intr = '0;
    #2;
    o = obs_now(); n_checks++;
    if (o !== ev(0, 0, 1, 0, 0, 0, 0, 0, '0)) begin
      n_fail++; $display("FAIL after_reset_fetch: got %b expected %b", o, ev(0, 0, 1, 0, 0, 0, 0, 0, '0));
    end else n_pass++;
    // pending was wiped, so no interrupt follows even with mie high
    k = 0;
    run_instr(OPC_IMM, 3'b000, 0, 0, 1'b1, '0, '0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL post_reset_instr cycle %0d: got %b expected %b", k, o, e); end
      else n_pass++;
      k++;
    end
  endtask

  initial begin
    test_reset();
    test_op_imm();
    test_load_delayed();
    test_interrupts();
    test_mie_gate();
    test_set_clear_collision();
    test_opcodes();
    test_illegal();
    test_random();
    test_reset_mid_store();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/otter_cu_fsm.md
OTTER_CU_FSM -- requirements
Module: otter_cu_fsm

Interface
REQ-001 The module SHALL have parameter NUM_INT, default 4, meaning the number of interrupt request channels (range 1..16).
REQ-002 The module SHALL have localparam CW = $clog2(NUM_INT+1), the int_cause width.
REQ-003 The module SHALL have port CLK, input, 1, the single system clock; all state changes occur on its rising edge.
REQ-004 The module SHALL have port RST, input, 1, the reset: asynchronous and active-high.
REQ-005 The module SHALL have port opcode, input, 7, ir[6:0].
REQ-006 The module SHALL have port func3, input, 3, ir[14:12].
REQ-007 The module SHALL have port intr, input, NUM_INT, interrupt requests sampled every cycle.
REQ-008 The module SHALL have port mie, input, 1, the global interrupt enable.
REQ-009 The module SHALL have port mem_ack, input, 1, memory-access complete; it is valid in the same cycle as the request.
REQ-010 The module SHALL have outputs pc_write, reg_write, mem_rden1, mem_rden2, mem_we2, csr_we, int_taken and mret_exec, each 1 bit and each a strobe.
REQ-011 The module SHALL have port int_cause, output, CW, the index of the serviced cause.

Function
REQ-012 States SHALL be FETCH, EXEC, WB and INTR; outputs SHALL be Moore/Mealy on state, opcode, func3 and mem_ack only.
REQ-013 FETCH: mem_rden1=1 until mem_ack=1, then the next state is EXEC; zero-wait ack (ack in the first cycle) SHALL give a 1-cycle fetch.
REQ-014 EXEC LOAD: mem_rden2=1 until mem_ack, then the next state is WB, with no pc_write in EXEC.
REQ-015 EXEC STORE: mem_we2=1 until mem_ack; pc_write=1 in the ack cycle.
REQ-016 EXEC LUI/AUIPC/JAL/JALR/OP_IMM/OP_RG3: pc_write=1 and reg_write=1 for one cycle.
REQ-017 EXEC BRANCH: pc_write=1 only; branch resolution stays in the decoder.
REQ-018 EXEC SYS func3=001 (CSRRW): pc_write, reg_write and csr_we SHALL each be 1.
REQ-019 EXEC SYS func3=000 (MRET): pc_write=1 and mret_exec=1.
REQ-020 EXEC SYS with any other func3: pc_write=1 only.
REQ-021 WB: reg_write=1 and pc_write=1 for one cycle.
REQ-022 Leaving EXEC (on completion) or WB: if mie=1 and pending!=0 the next state SHALL be INTR, else FETCH.
REQ-023 pending[NUM_INT-1:0] register: bit i set when intr[i]=1, cleared when serviced in INTR; a simultaneous set and clear on the same bit SHALL leave it set.
REQ-024 INTR: int_taken=1 and pc_write=1 for one cycle; int_cause = lowest-index pending bit (index 0 highest priority); that bit is cleared; the next state is FETCH.
REQ-025 int_cause SHALL be 0 outside INTR.
REQ-026 Interrupts SHALL never preempt FETCH, or EXEC while waiting on mem_ack.

Reset
REQ-027 RST=1 SHALL asynchronously force state=FETCH and pending=0.
REQ-028 While RST=1, every output SHALL be 0, including mem_rden1.
REQ-029 Reset mid-access SHALL abandon the access; the first cycle after release is FETCH.

Configuration
REQ-030 Macro CU_ILLEGAL_TRAP_EN SHALL control illegal-opcode trapping.
REQ-031 With CU_ILLEGAL_TRAP_EN defined, an unlisted opcode in EXEC SHALL assert no strobes and go to INTR regardless of mie, with int_cause=NUM_INT and pending untouched.
REQ-032 With CU_ILLEGAL_TRAP_EN undefined, an unlisted opcode SHALL execute as a NOP (pc_write=1 only).

Structure
REQ-033 Package otter_cu_pkg SHALL hold the opcode_t enum (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP_RG3, SYS), the state_t enum and the SYS func3 constants.
REQ-034 Sub-module int_prio_enc SHALL be parametrised by NUM_INT, with pending as input and {valid, index[CW-1:0]} as outputs.

Verification
REQ-035 Reset then OP_IMM, mem_ack tied 1 -> FETCH(rden1) then EXEC(pc_write, reg_write); a 2-cycle instruction.
REQ-036 LOAD, ack delayed 3 cycles in each phase -> rden1 held 3 cycles, rden2 held 3 cycles, then WB with reg_write+pc_write; 7 cycles total.
REQ-037 NUM_INT=4, intr=4'b1010 pulsed during FETCH, mie=1 -> after EXEC, INTR with int_cause=1, then INTR again later with int_cause=3.
REQ-038 mie=0 with pending=4'b0001 -> no INTR entered; raising mie -> INTR at the next EXEC exit.
REQ-039 With CU_ILLEGAL_TRAP_EN, opcode=7'h7F, mie=0 -> INTR, int_cause=4, no reg_write; without the macro -> pc_write only.
REQ-040 RST asserted mid-STORE wait -> mem_we2 drops immediately; after release, rden1 asserts in FETCH.
